fine_delay_line: RTL and testbench



---
 rtl/fine_delay_line.sv | 85 ++++++++
 tb/tb_fine_delay_line.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fine_delay_line.sv
// Fine delay line: delays a {ce, data} sample stream by 0..MAX_DELAY clock
// cycles. The delay changes only when no strobe can be dropped or repeated.
// Optional macro FINE_DELAY_HOLD_EN: data_o holds its value between ce_o pulses.
module fine_delay_line #(
  parameter int unsigned WIDTH      = 14,
  parameter int unsigned DELAY_BITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ce_i,
  input  logic [DELAY_BITS-1:0] delay_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic                  ce_o,
  output logic [WIDTH-1:0]      data_o,
  output logic [DELAY_BITS-1:0] delay_o
);

  localparam int unsigned MAX_DELAY = (1 << DELAY_BITS) - 1;

  // Stage k holds the sample taken k cycles ago. A strobe's ce bit is cleared
  // once the output stage has taken it, so a later delay change cannot emit
  // it a second time and the idle test only sees strobes still in flight.
  logic [MAX_DELAY:1]    sr_ce;
  logic [WIDTH-1:0]      sr_data [1:MAX_DELAY];
  logic [DELAY_BITS-1:0] pending;

  logic                  in_flight;
  logic                  update;
  logic                  bypass;
  logic [DELAY_BITS-1:0] sel;
  logic                  tap_ce;
  logic [WIDTH-1:0]      tap_data;

  // Update detection and tap selection. A strobe arriving on an update cycle
  // that switches to delay 0 goes straight to the output stage, so it leaves
  // with the new delay instead of being stranded in stage 1.
  always_comb begin
    in_flight = |sr_ce;
    update    = ce_o | (~ce_i & ~in_flight);
    bypass    = update && (pending == '0);
    sel       = bypass ? '0 : delay_o;
    tap_ce    = ce_i;
    tap_data  = data_i;
    for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
      if (sel == DELAY_BITS'(k)) begin
        tap_ce   = sr_ce[k];
        tap_data = sr_data[k];
      end
    end
  end

  // Shift register, delay bookkeeping and registered output stage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_ce   <= '0;
      for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
        sr_data[k] <= '0;
      end
      pending <= '0;
      delay_o <= '0;
      ce_o    <= 1'b0;
      data_o  <= '0;
    end else begin
      sr_ce[1]   <= ce_i & (sel != '0);
      sr_data[1] <= data_i;
      for (int unsigned k = 2; k <= MAX_DELAY; k++) begin
        sr_ce[k]   <= sr_ce[k-1] & (sel != DELAY_BITS'(k - 1));
        sr_data[k] <= sr_data[k-1];
      end
      pending <= delay_i;
      if (update) begin
        delay_o <= pending;
      end
      ce_o <= tap_ce;
`ifdef FINE_DELAY_HOLD_EN
      if (tap_ce) begin
        data_o <= tap_data;
      end
`else
      data_o <= tap_data;
`endif
    end
  end

endmodule

// File: tb/tb_fine_delay_line.sv
// Self-checking bench for fine_delay_line (WIDTH=14, DELAY_BITS=3).
// A time-based model tracks every strobe by its capture cycle and decides
// when it must leave; a compare step checks the DUT against it each cycle.
module tb_fine_delay_line;

  localparam int W   = 14;
  localparam int DB  = 3;
  localparam int MAX = 7;

  logic          clk;
  logic          rst_n;
  logic          ce_in;
  logic [DB-1:0] delay_in;
  logic [W-1:0]  data_in;
  logic          ce_out;
  logic [W-1:0]  data_out;
  logic [DB-1:0] delay_out;

  fine_delay_line #(.WIDTH(W), .DELAY_BITS(DB)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .ce_i    (ce_in),
    .delay_i (delay_in),
    .data_i  (data_in),
    .ce_o    (ce_out),
    .data_o  (data_out),
    .delay_o (delay_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: strobes waiting to leave, tagged with their capture cycle.
  typedef struct {
    int           born;
    logic [W-1:0] data;
  } strobe_t;

  strobe_t       q[$];
  int            cyc = 0;
  logic          m_ce = 1'b0;
  logic [W-1:0]  m_data = '0;
  bit            m_data_known = 1'b0;
  logic [DB-1:0] m_delay = '0;
  logic [DB-1:0] m_pending = '0;

  bit            burst = 1'b0;
  logic          last_ce = 1'b0;
  logic [DB-1:0] last_delay = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_step();
    bit           upd;
    int           s;
    bit           hit;
    logic [W-1:0] hd;
    if (!rst_n) begin
      q.delete();
      m_ce = 1'b0; m_data = '0; m_data_known = 1'b1;
      m_delay = '0; m_pending = '0;
      cyc++;
      return;
    end
    upd = m_ce || (!ce_in && q.size() == 0);
    s   = (upd && m_pending == '0) ? 0 : int'(m_delay);
    hit = 1'b0;
    hd  = '0;
    if (s == 0) begin
      if (ce_in) begin hit = 1'b1; hd = data_in; end
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        if (cyc - q[i].born == s) begin
          hit = 1'b1; hd = q[i].data;
          q.delete(i);
          break;
        end
      end
    end
    if (ce_in && s != 0) q.push_back('{cyc, data_in});
    cyc++;
    while (q.size() > 0 && cyc - q[0].born > MAX) void'(q.pop_front());
    if (upd) m_delay = m_pending;
    m_pending = delay_in;
    m_ce = hit;
`ifdef FINE_DELAY_HOLD_EN
    if (hit) m_data = hd;
    m_data_known = 1'b1;
`else
    m_data = hd;
    m_data_known = hit;
`endif
  endtask

  task automatic compare();
    check("no_x", 32'($isunknown({ce_out, data_out, delay_out})), 32'd0);
    check("ce_o", 32'(ce_out), 32'(m_ce));
    check("delay_o", 32'(delay_out), 32'(m_delay));
    if (m_data_known) check("data_o", 32'(data_out), 32'(m_data));
    if (burst && delay_out != last_delay) check("delay_change_on_ce_o", 32'(last_ce), 32'd1);
    last_ce    = ce_out;
    last_delay = delay_out;
  endtask

  task automatic tick(input bit rst, input bit ce, input logic [W-1:0] d, input logic [DB-1:0] dl);
    @(negedge clk);
    rst_n = rst; ce_in = ce; data_in = d; delay_in = dl;
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  // One strobe, then wait (bounded) for ce_o and check latency and data;
  // pads the slot to an 8-cycle strobe period.
  task automatic strobe_lat(input logic [W-1:0] d, input logic [DB-1:0] dl, input int exp_lat, input string name);
    int n;
    tick(1, 1, d, dl);
    n = 1;
    while (!ce_out && n < 20) begin
      tick(1, 0, '0, dl);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_data"}, 32'(data_out), 32'(d));
    check({name, "_delay_o"}, 32'(delay_out), 32'(dl));
    while (n < 8) begin
      tick(1, 0, '0, dl);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] dl;
    rst_n = 1'b0; ce_in = 1'b0; data_in = '0; delay_in = '0;

    // Reset with ce_i active.
    tick(0, 1, 14'd555, 3'd0);
    tick(0, 1, 14'd555, 3'd0);
    check("rst_ce_o", 32'(ce_out), 32'd0);
    check("rst_data_o", 32'(data_out), 32'd0);
    check("rst_delay_o", 32'(delay_out), 32'd0);
    for (int i = 0; i < 8; i++) tick(1, 0, '0, 3'd0);

    // Delay 0: one cycle latency.
    for (int i = 0; i < 3; i++) strobe_lat(14'd100, 3'd0, 1, "d0");

    // Switch 0 -> 5 between strobes.
    for (int i = 0; i < 4; i++) tick(1, 0, '0, 3'd5);
    check("d5_delay_o", 32'(delay_out), 32'd5);
    for (int i = 0; i < 3; i++) strobe_lat(14'd99, 3'd5, 6, "d5");

    // Switch 7 -> 0 with a strobe in flight; next strobe coincides with ce_o.
    for (int i = 0; i < 4; i++) tick(1, 0, '0, 3'd7);
    check("d7_delay_o", 32'(delay_out), 32'd7);
    tick(1, 1, 14'd1234, 3'd7);
    for (int i = 0; i < 7; i++) tick(1, 0, '0, 3'd0);
    check("d7_old_ce_o", 32'(ce_out), 32'd1);
    check("d7_old_data", 32'(data_out), 32'd1234);
    check("d7_old_delay", 32'(delay_out), 32'd7);
    tick(1, 1, 14'd4321, 3'd0);
    check("d0_new_ce_o", 32'(ce_out), 32'd1);
    check("d0_new_data", 32'(data_out), 32'd4321);
    check("d0_new_delay", 32'(delay_out), 32'd0);
    for (int i = 0; i < 7; i++) tick(1, 0, '0, 3'd0);

    // Mid-stream reset discards in-flight strobes.
    for (int i = 0; i < 4; i++) tick(1, 0, '0, 3'd4);
    tick(1, 1, 14'd777, 3'd4);
    tick(1, 0, '0, 3'd4);
    tick(0, 1, 14'd888, 3'd4);
    check("mid_rst_ce_o", 32'(ce_out), 32'd0);
    check("mid_rst_delay_o", 32'(delay_out), 32'd0);
    for (int i = 0; i < 10; i++) tick(1, 0, '0, 3'd4);

    // Hold behaviour at delay 3.
    for (int i = 0; i < 4; i++) tick(1, 0, '0, 3'd3);
    strobe_lat(14'd98, 3'd3, 4, "hold98");
`ifdef FINE_DELAY_HOLD_EN
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 14'(i + 5), 3'd3);
      check("hold_data_o", 32'(data_out), 32'd98);
    end
`endif
    strobe_lat(14'd97, 3'd3, 4, "hold97");

    // Random strobes with period >= MAX_DELAY+1 and random delay changes.
    dl = 3'd2;
    for (int s = 0; s < 60; s++) begin
      int gap;
      gap = int'($urandom_range(12, 8));
      tick(1, 1, 14'($urandom), dl);
      for (int i = 1; i < gap; i++) begin
        if ($urandom_range(7, 0) == 0) dl = 3'($urandom);
        tick(1, 0, 14'($urandom), dl);
      end
    end

    // Continuous ce_i with delay toggled 2 <-> 6.
    burst = 1'b1;
    dl = 3'd2;
    for (int i = 0; i < 48; i++) begin
      if (i % 5 == 4) dl = (dl == 3'd2) ? 3'd6 : 3'd2;
      tick(1, 1, 14'($urandom), dl);
    end
    burst = 1'b0;
    for (int i = 0; i < 16; i++) tick(1, 0, '0, dl);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
